// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and elaboration helpers for the MEM-stage SRAM controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned BASE_ADDR_DEFAULT = 1024;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned beats(input int unsigned data_w, input int unsigned sram_dw);
    return data_w / sram_dw;
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// CPU-side load/store handshake between the MEM stage and the SRAM controller.
interface sram_mem_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              not_ready;

  modport master (output rd_en, wr_en, addr, wdata, input rdata, not_ready);
  modport slave  (input rd_en, wr_en, addr, wdata, output rdata, not_ready);
endinterface

// File: rtl/sram_beat_timer.sv
// Wait-state and beat counters for one multi-beat SRAM access.
module sram_beat_timer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 5,
  parameter int unsigned BEATS    = 2,
  parameter int unsigned BEAT_W   = (BEATS > 1) ? clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [BEAT_W-1:0] beat,
  output logic              last_cycle,
  output logic              last_beat
);
  localparam int unsigned WAIT_W = clog2(WAIT_CYC);

  logic [WAIT_W-1:0] wait_cnt;

  assign last_cycle = (wait_cnt == WAIT_W'(WAIT_CYC - 1));
  assign last_beat  = (beat == BEAT_W'(BEATS - 1));

  // Counters sit at zero whenever no access is running, so every access starts clean.
  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (last_cycle) begin
      wait_cnt <= '0;
      if (!last_beat) beat <= beat + BEAT_W'(1);
    end else begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
endmodule

// File: rtl/sram_mem_ctrl.sv
// Splits one wide CPU load/store into SRAM-width beats with fixed wait states,
// stalling the pipeline until the access completes.
module sram_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SRAM_DW   = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned SRAM_AW   = 18,
  parameter int unsigned WAIT_CYC  = 5,
  parameter int unsigned BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_ctrl_if.slave     bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  inout  wire  [SRAM_DW-1:0] sram_dq
);
  localparam int unsigned BEATS   = beats(DATA_W, SRAM_DW);
  localparam int unsigned BEAT_W  = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int unsigned BYTE_SH = clog2(DATA_W / 8);

  if ((DATA_W % SRAM_DW) != 0 || WAIT_CYC < 2) begin : g_cfg_check
    $error("sram_mem_ctrl: DATA_W must be a multiple of SRAM_DW and WAIT_CYC must be >= 2");
  end

  state_t              state;
  logic                op_write;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [BEAT_W-1:0]   beat;
  logic                last_cycle;
  logic                last_beat;
  logic                req;
  logic                drive_en;
  logic [SRAM_DW-1:0]  wslice;
  logic [SRAM_AW-1:0]  start_addr;

  sram_beat_timer #(
    .WAIT_CYC (WAIT_CYC),
    .BEATS    (BEATS),
    .BEAT_W   (BEAT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (state == ACCESS),
    .beat       (beat),
    .last_cycle (last_cycle),
    .last_beat  (last_beat)
  );

  assign req           = bus.rd_en | bus.wr_en;
  assign bus.not_ready = req && (state != DONE);
  assign bus.rdata     = rdata_q;

  // Word index scaled by beats per word; wraps modulo the SRAM address space below BASE_ADDR.
  assign start_addr = SRAM_AW'(((bus.addr - ADDR_W'(BASE_ADDR)) >> BYTE_SH) * ADDR_W'(BEATS));

  assign drive_en  = (state == ACCESS) && op_write;
  assign sram_we_n = !(drive_en && !last_cycle);
  assign sram_dq   = drive_en ? wslice : 'z;

  always_comb begin
    wslice = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) wslice = wdata_q[b*SRAM_DW +: SRAM_DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      op_write  <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      sram_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= ACCESS;
            op_write  <= bus.wr_en;
            wdata_q   <= bus.wdata;
            sram_addr <= start_addr;
          end
        end
        ACCESS: begin
          if (last_cycle) begin
            if (!op_write) begin
              for (int unsigned b = 0; b < BEATS; b++) begin
                if (beat == BEAT_W'(b)) rdata_q[b*SRAM_DW +: SRAM_DW] <= sram_dq;
              end
            end
            if (last_beat) state <= DONE;
            else           sram_addr <= sram_addr + SRAM_AW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
